// File: rtl/ex_cc_mreg.sv
// ex_cc_mreg: execute-stage tail of the Y86-64 pipeline.
//
// This block holds the condition-code register, evaluates the jump/cmov
// condition for the instruction in E, and holds the E->M pipeline register.
//
// Ports:
//   clk, rst_n          pipeline clock and synchronous active-low reset
//   E_stat .. E_dstM    fields of the instruction currently in E
//   alu_valE, alu_cf    ALU result and its flags {OF,SF,ZF}
//   m_stat, W_stat      statuses further down the pipe (these gate CC updates)
//   M_bubble            load a NOP into M on this edge
//   cc                  current condition codes {OF,SF,ZF}
//   e_cnd, e_dstE       combinational condition result and squashed dstE
//   M_*                 contents of the M pipeline register
module ex_cc_mreg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [W-1:0] alu_valE,
    input  logic [2:0]   alu_cf,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    input  logic         M_bubble,
    output logic [2:0]   cc,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [2:0] STAT_AOK   = 3'd1;
    localparam logic [2:0] STAT_HLT   = 3'd2;
    localparam logic [2:0] STAT_ADR   = 3'd3;
    localparam logic [2:0] STAT_INS   = 3'd4;
    localparam logic [3:0] ICODE_NOP  = 4'd1;
    localparam logic [3:0] ICODE_CMOV = 4'd2;
    localparam logic [3:0] ICODE_OPQ  = 4'd6;
    localparam logic [3:0] RNONE      = 4'hF;
    localparam logic [2:0] CC_RESET   = 3'b001;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
    endfunction

    logic [2:0]   cc_q,      cc_d;
    logic [2:0]   m_stat_q,  m_stat_d;
    logic [3:0]   m_icode_q, m_icode_d;
    logic         m_cnd_q,   m_cnd_d;
    logic [W-1:0] m_vale_q,  m_vale_d;
    logic [W-1:0] m_vala_q,  m_vala_d;
    logic [3:0]   m_dste_q,  m_dste_d;
    logic [3:0]   m_dstm_q,  m_dstm_d;

    logic set_cc;
    logic zf, sf, of_flag;

    always_comb begin
        zf      = cc_q[0];
        sf      = cc_q[1];
        of_flag = cc_q[2];

        // Condition evaluates against the pre-update flags, for every icode.
        e_cnd = 1'b0;
        case (E_ifun)
            4'd0:    e_cnd = 1'b1;
            4'd1:    e_cnd = (sf ^ of_flag) | zf;
            4'd2:    e_cnd = sf ^ of_flag;
            4'd3:    e_cnd = zf;
            4'd4:    e_cnd = ~zf;
            4'd5:    e_cnd = ~(sf ^ of_flag);
            4'd6:    e_cnd = ~(sf ^ of_flag) & ~zf;
            default: e_cnd = 1'b0;
        endcase

        // A cmov that is not taken writes no register.
        e_dstE = ((E_icode == ICODE_CMOV) && !e_cnd) ? RNONE : E_dstE;

        // An older instruction that faulted must not see flags from a younger OPq.
        set_cc = (E_icode == ICODE_OPQ) && !is_exc(m_stat) && !is_exc(W_stat);
        cc_d   = set_cc ? alu_cf : cc_q;

        if (M_bubble) begin
            m_stat_d  = STAT_AOK;
            m_icode_d = ICODE_NOP;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = RNONE;
            m_dstm_d  = RNONE;
        end else begin
            m_stat_d  = E_stat;
            m_icode_d = E_icode;
            m_cnd_d   = e_cnd;
            m_vale_d  = alu_valE;
            m_vala_d  = E_valA;
            m_dste_d  = e_dstE;
            m_dstm_d  = E_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q      <= CC_RESET;
            m_stat_q  <= STAT_AOK;
            m_icode_q <= ICODE_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            cc_q      <= cc_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

endmodule

// File: tb/tb_ex_cc_mreg.sv
module tb_ex_cc_mreg;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valA;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [W-1:0] alu_valE;
    logic [2:0]   alu_cf;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;
    logic         M_bubble;
    logic [2:0]   cc;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    ex_cc_mreg #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .alu_valE(alu_valE), .alu_cf(alu_cf),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .cc(cc), .e_cnd(e_cnd), .e_dstE(e_dstE),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         mdl_valid = 1'b0;
    logic         mzf, msf, mof;
    logic [2:0]   mm_stat;
    logic [3:0]   mm_icode;
    logic         mm_cnd;
    logic [63:0]  mm_vale, mm_vala;
    logic [3:0]   mm_dste, mm_dstm;

    function automatic bit faulted(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    function automatic bit mdl_cond(input logic [3:0] fn);
        bit less = (msf != mof);
        case (fn)
            4'd0: return 1'b1;
            4'd1: return less || mzf;
            4'd2: return less;
            4'd3: return mzf;
            4'd4: return !mzf;
            4'd5: return !less;
            4'd6: return !less && !mzf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] mdl_dste();
        if (E_icode == 4'd2 && !mdl_cond(E_ifun)) return 4'hF;
        return E_dstE;
    endfunction

    task automatic mdl_check_comb();
        if (mdl_valid) begin
            chk("mdl_e_cnd", {63'd0, e_cnd}, {63'd0, mdl_cond(E_ifun)});
            chk("mdl_e_dstE", {60'd0, e_dstE}, {60'd0, mdl_dste()});
        end
    endtask

    // Called just before the edge with inputs still stable.
    task automatic mdl_step();
        bit       c   = mdl_cond(E_ifun);
        logic [3:0] d = mdl_dste();
        if (!rst_n) begin
            {mof, msf, mzf} = 3'b001;
            mm_stat = 3'd1; mm_icode = 4'd1; mm_cnd = 1'b0;
            mm_vale = '0; mm_vala = '0; mm_dste = 4'hF; mm_dstm = 4'hF;
            mdl_valid = 1'b1;
        end else begin
            if (E_icode == 4'd6 && !faulted(m_stat) && !faulted(W_stat))
                {mof, msf, mzf} = alu_cf;
            if (M_bubble) begin
                mm_stat = 3'd1; mm_icode = 4'd1; mm_cnd = 1'b0;
                mm_vale = '0; mm_vala = '0; mm_dste = 4'hF; mm_dstm = 4'hF;
            end else begin
                mm_stat = E_stat; mm_icode = E_icode; mm_cnd = c;
                mm_vale = alu_valE; mm_vala = E_valA; mm_dste = d; mm_dstm = E_dstM;
            end
        end
    endtask

    task automatic mdl_check_regs();
        if (mdl_valid) begin
            chk("mdl_cc", {61'd0, cc}, {61'd0, mof, msf, mzf});
            chk("mdl_M_stat", {61'd0, M_stat}, {61'd0, mm_stat});
            chk("mdl_M_icode", {60'd0, M_icode}, {60'd0, mm_icode});
            chk("mdl_M_cnd", {63'd0, M_cnd}, {63'd0, mm_cnd});
            chk("mdl_M_valE", M_valE, mm_vale);
            chk("mdl_M_valA", M_valA, mm_vala);
            chk("mdl_M_dstE", {60'd0, M_dstE}, {60'd0, mm_dste});
            chk("mdl_M_dstM", {60'd0, M_dstM}, {60'd0, mm_dstm});
        end
    endtask

    // One full cycle: inputs already driven; check comb, clock, check regs.
    task automatic tick();
        #1;
        mdl_check_comb();
        mdl_step();
        @(posedge clk);
        #1;
        mdl_check_regs();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  dste;
        logic [63:0] vale;
        logic [2:0]  cf;
        logic [2:0]  mst;
        logic [2:0]  wst;
        logic        bub;
        logic        chk_cnd;
        logic        x_cnd;
        logic [3:0]  x_edste;
        logic [2:0]  x_cc;
        logic [2:0]  x_mstat;
        logic [3:0]  x_micode;
        logic [3:0]  x_mdste;
        logic [63:0] x_mvale;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
        input logic [3:0] dste, input logic [63:0] vale, input logic [2:0] cf,
        input logic [2:0] mst, input logic [2:0] wst, input logic bub,
        input logic chk_cnd, input logic x_cnd, input logic [3:0] x_edste,
        input logic [2:0] x_cc, input logic [2:0] x_mstat, input logic [3:0] x_micode,
        input logic [3:0] x_mdste, input logic [63:0] x_mvale);
        vec_t v;
        v.rst = rst; v.stat = stat; v.icode = icode; v.ifun = ifun; v.dste = dste;
        v.vale = vale; v.cf = cf; v.mst = mst; v.wst = wst; v.bub = bub;
        v.chk_cnd = chk_cnd; v.x_cnd = x_cnd; v.x_edste = x_edste; v.x_cc = x_cc;
        v.x_mstat = x_mstat; v.x_micode = x_micode; v.x_mdste = x_mdste; v.x_mvale = x_mvale;
        return v;
    endfunction

    logic [15:0] sweep_exp;

    initial begin
        rst_n = 1'b0; E_stat = 3'd1; E_icode = 4'd1; E_ifun = 4'd0;
        E_valA = '0; E_dstE = 4'hF; E_dstM = 4'hF; alu_valE = '0; alu_cf = 3'b000;
        m_stat = 3'd1; W_stat = 3'd1; M_bubble = 1'b0;
        @(negedge clk);

        // reset overriding an OPq
        tbl.push_back(mk(0,1,6,0,4'hF,64'h0,3'b110,1,1,0, 0,1,4'hF, 3'b001,1,1,4'hF,64'h0));
        // OPq updates flags
        tbl.push_back(mk(1,1,6,0,4'h2,64'h10,3'b010,1,1,0, 1,1,4'h2, 3'b010,1,6,4'h2,64'h10));
        // jl with SF=1: taken, flags held
        tbl.push_back(mk(1,1,7,2,4'hF,64'h0,3'b000,1,1,0, 1,1,4'hF, 3'b010,1,7,4'hF,64'h0));
        // OPq while memory stage faulted (ADR): flags held, still latched into M
        tbl.push_back(mk(1,1,6,0,4'h5,64'h20,3'b001,3,1,0, 1,1,4'h5, 3'b010,1,6,4'h5,64'h20));
        // OPq while writeback faulted (INS): flags held
        tbl.push_back(mk(1,1,6,0,4'h5,64'h30,3'b001,1,4,0, 1,1,4'h5, 3'b010,1,6,4'h5,64'h30));
        // OPq sets OF=1, ZF=1
        tbl.push_back(mk(1,1,6,0,4'h6,64'h40,3'b101,1,1,0, 1,1,4'h6, 3'b101,1,6,4'h6,64'h40));
        // condition sweep with cc=101
        sweep_exp = 16'h000F;
        for (int f = 0; f < 16; f++)
            tbl.push_back(mk(1,1,7,f[3:0],4'hF,64'h0,3'b000,1,1,0, 1,sweep_exp[f],4'hF,
                             3'b101,1,7,4'hF,64'h0));
        // back to cc=001
        tbl.push_back(mk(1,1,6,0,4'hF,64'h0,3'b001,1,1,0, 1,1,4'hF, 3'b001,1,6,4'hF,64'h0));
        // cmovne not taken: dstE squashed
        tbl.push_back(mk(1,1,2,4,4'h3,64'h50,3'b000,1,1,0, 1,0,4'hF, 3'b001,1,2,4'hF,64'h50));
        // cmove taken: dstE kept
        tbl.push_back(mk(1,1,2,3,4'h3,64'h60,3'b000,1,1,0, 1,1,4'h3, 3'b001,1,2,4'h3,64'h60));
        // bubble alongside OPq: flags update, M gets NOP
        tbl.push_back(mk(1,1,6,0,4'h7,64'h70,3'b100,1,1,1, 1,1,4'h7, 3'b100,1,1,4'hF,64'h0));
        // HLT status in E flows to M
        tbl.push_back(mk(1,2,7,0,4'hF,64'h80,3'b000,1,1,0, 1,1,4'hF, 3'b100,2,7,4'hF,64'h80));
        // reset mid-stream discards the instruction
        tbl.push_back(mk(0,1,5,0,4'h8,64'h90,3'b111,1,1,0, 1,1,4'h8, 3'b001,1,1,4'hF,64'h0));
        // OPq with writeback HLT: flags held at reset value
        tbl.push_back(mk(1,1,6,0,4'h9,64'hA0,3'b110,1,2,0, 1,1,4'h9, 3'b001,1,6,4'h9,64'hA0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst; E_stat = tbl[i].stat; E_icode = tbl[i].icode;
            E_ifun = tbl[i].ifun; E_dstE = tbl[i].dste; alu_valE = tbl[i].vale;
            alu_cf = tbl[i].cf; m_stat = tbl[i].mst; W_stat = tbl[i].wst;
            M_bubble = tbl[i].bub; E_valA = '0; E_dstM = 4'hF;
            #1;
            if (tbl[i].chk_cnd) begin
                chk($sformatf("v%0d_e_cnd", i), {63'd0, e_cnd}, {63'd0, tbl[i].x_cnd});
                chk($sformatf("v%0d_e_dstE", i), {60'd0, e_dstE}, {60'd0, tbl[i].x_edste});
            end
            mdl_check_comb();
            mdl_step();
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cc", i), {61'd0, cc}, {61'd0, tbl[i].x_cc});
            chk($sformatf("v%0d_M_stat", i), {61'd0, M_stat}, {61'd0, tbl[i].x_mstat});
            chk($sformatf("v%0d_M_icode", i), {60'd0, M_icode}, {60'd0, tbl[i].x_micode});
            chk($sformatf("v%0d_M_dstE", i), {60'd0, M_dstE}, {60'd0, tbl[i].x_mdste});
            chk($sformatf("v%0d_M_valE", i), M_valE, tbl[i].x_mvale);
            mdl_check_regs();
        end

        // passthrough of values, then a bubble clears them
        rst_n = 1'b1; M_bubble = 1'b0; E_stat = 3'd1; E_icode = 4'd5; E_ifun = 4'd0;
        alu_valE = 64'hFFFF_FFFF_FFFF_FFF8; E_valA = 64'h1234; E_dstM = 4'd4; E_dstE = 4'hF;
        m_stat = 3'd1; W_stat = 3'd1;
        tick();
        chk("pass_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("pass_M_valA", M_valA, 64'h1234);
        chk("pass_M_dstM", {60'd0, M_dstM}, 64'd4);
        chk("pass_M_icode", {60'd0, M_icode}, 64'd5);
        M_bubble = 1'b1;
        tick();
        chk("bub_M_valA", M_valA, 64'h0);
        chk("bub_M_dstM", {60'd0, M_dstM}, 64'hF);
        chk("bub_M_cnd", {63'd0, M_cnd}, 64'd0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            rst_n = ($urandom_range(0, 63) != 0);
            M_bubble = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 7);
            case (r)
                0, 1, 2: E_icode = 4'd6;
                3:       E_icode = 4'd2;
                4:       E_icode = 4'd7;
                default: E_icode = 4'($urandom_range(0, 15));
            endcase
            E_ifun   = 4'($urandom_range(0, 15));
            E_stat   = 3'($urandom_range(1, 4));
            E_dstE   = 4'($urandom_range(0, 15));
            E_dstM   = 4'($urandom_range(0, 15));
            E_valA   = {$urandom, $urandom};
            alu_valE = {$urandom, $urandom};
            alu_cf   = 3'($urandom_range(0, 7));
            m_stat   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            W_stat   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_cc_mreg.md
# ex_cc_mreg

Execute-stage tail of the Y86-64 pipeline: owns the 3-bit condition-code register (ZF, SF, OF), evaluates the jump/cmov condition `e_cnd`, and holds the E→M pipeline register feeding the memory stage. It consumes the execute adder's result and its 3-bit flag vector (`[0]`=ZF, `[1]`=SF, `[2]`=OF), gates CC updates on downstream exception status, and inserts NOP bubbles into M on request.

## Interface
Parameters:
- `W`, 64, datapath width for valE/valA.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `E_stat`  in  3  status of instruction in E (AOK=1, HLT=2, ADR=3, INS=4).
- `E_icode`  in  4  icode in E (OPq=6, cmovXX=2, jXX=7, NOP=1).
- `E_ifun`  in  4  function code in E.
- `E_valA`  in  W  operand A forwarded to M.
- `E_dstE`  in  4  destination register E (0xF = RNONE).
- `E_dstM`  in  4  destination register M.
- `alu_valE`  in  W  execute adder/ALU result.
- `alu_cf`  in  3  flags from ALU: `[0]` ZF, `[1]` SF, `[2]` OF.
- `m_stat`  in  3  status currently leaving memory stage.
- `W_stat`  in  3  status in writeback register.
- `M_bubble`  in  1  load NOP bubble into M register this edge.
- `cc`  out  3  current condition codes `{OF,SF,ZF}`.
- `e_cnd`  out  1  combinational condition result for instruction in E.
- `e_dstE`  out  4  combinational dstE after cmov squash (for forwarding).
- `M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM`  out  3/4/1/W/W/4/4  M pipeline register contents.

## Operation
- Exception status set X = {HLT, ADR, INS}.
- `set_cc` = (E_icode==6) && m_stat∉X && W_stat∉X.
- CC: on edge, if `set_cc`, `cc <= alu_cf`; else hold. Independent of `M_bubble`.
- `e_cnd` from current (pre-update) `cc`, by E_ifun: 0 → 1; 1 le → (SF^OF)|ZF; 2 l → SF^OF; 3 e → ZF; 4 ne → ~ZF; 5 ge → ~(SF^OF); 6 g → ~(SF^OF)&~ZF; 7–15 → 0. Evaluated for all icodes; consumers use it only for icode 2/7.
- `e_dstE` = RNONE (0xF) when E_icode==2 && !e_cnd, else E_dstE.
- M register on edge, priority: `!rst_n` > `M_bubble` > load.
  - Load: M_stat<=E_stat, M_icode<=E_icode, M_cnd<=e_cnd, M_valE<=alu_valE, M_valA<=E_valA, M_dstE<=e_dstE, M_dstM<=E_dstM.
  - Bubble/reset value: stat=AOK(1), icode=NOP(1), cnd=0, valE=0, valA=0, dstE=0xF, dstM=0xF.
- No stall input: M register loads or bubbles every cycle.

## Timing
- Reset (rst_n low at edge): cc=3'b001 (ZF=1, SF=0, OF=0); M register = bubble value. Reset overrides `set_cc` and load in the same edge; reset mid-stream discards the in-flight instruction.
- Latency: E inputs → M outputs 1 cycle. `e_cnd`, `e_dstE` 0-cycle combinational.
- OPq in E at cycle n updates `cc` at edge n+1; a jXX/cmov in E at cycle n+1 sees new flags; a jXX in E at cycle n alongside the OPq is impossible (one instruction per stage).
- OPq in E while m_stat or W_stat ∈ X: CC held; instruction still latched into M unless `M_bubble`.
- `M_bubble` asserted with OPq in E and no exceptions: CC still updates, M gets NOP.
- W-width arithmetic not performed here; `alu_valE` passes through unmodified.

## Test plan
- Reset: hold rst_n=0 one edge with E_icode=6, alu_cf=3'b110 → cc=3'b001, M_icode=1, M_dstE=0xF, M_stat=1.
- CC update/hold: OPq with alu_cf=3'b010 → cc=3'b010 next cycle; then E_icode=7 → cc unchanged; OPq with m_stat=3 (ADR), alu_cf=3'b001 → cc stays 3'b010.
- Condition table: cc=3'b101 (OF=1,ZF=1), sweep E_ifun 0–7 → e_cnd = 1,1,1,1,0,0,0,0.
- cmov squash: cc=3'b001, E_icode=2, E_ifun=4 (ne), E_dstE=3 → e_cnd=0, e_dstE=0xF, M_dstE=0xF; E_ifun=3 → M_dstE=3.
- Passthrough: E_icode=5, alu_valE=0xFFFF_FFFF_FFFF_FFF8, E_valA=0x1234, E_dstM=4, E_stat=1 → next cycle M_valE/M_valA/M_dstM match, M_icode=5.
- Bubble vs CC: OPq, alu_cf=3'b100, M_bubble=1 → M_icode=1, M_valE=0, cc=3'b100.
